// File: rtl/cla_accumulator.sv
// Packet accumulator wrapped around an external combinational CLA_32bit adder.
// Optional build macro CLA_ACC_SAT_EN saturates the wide sum on carry-count overflow.
module cla_accumulator #(
  parameter int unsigned HI_W   = 16,
  parameter int unsigned BEAT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic                 in_last,
  output logic [31:0]          cla_A,
  output logic [31:0]          cla_B,
  input  logic [31:0]          cla_Sum,
  input  logic                 cla_Cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32+HI_W-1:0]   out_sum,
  output logic [BEAT_W-1:0]    out_beats,
  output logic                 out_ovf
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e              state_q;
  logic [31:0]         acc_q;
  logic [HI_W-1:0]     hi_q;
  logic [BEAT_W-1:0]   beats_q;
  logic                ovf_q;

  logic                accept;
  logic [HI_W-1:0]     hi_base;
  logic [BEAT_W-1:0]   beats_base;
  logic                ovf_base;
  logic [31:0]         acc_d;
  logic [HI_W-1:0]     hi_d;
  logic [BEAT_W-1:0]   beats_d;
  logic                ovf_d;

  assign in_ready  = (state_q != StDone);
  assign cla_A     = (state_q == StIdle) ? 32'd0 : acc_q;
  assign cla_B     = in_data;
  assign accept    = in_valid && in_ready;

  assign out_valid = (state_q == StDone);
  assign out_sum   = {hi_q, acc_q};
  assign out_beats = beats_q;
  assign out_ovf   = ovf_q;

  // A packet starting from IDLE ignores whatever the previous packet left behind.
  always_comb begin
    hi_base    = (state_q == StIdle) ? '0 : hi_q;
    beats_base = (state_q == StIdle) ? '0 : beats_q;
    ovf_base   = (state_q == StIdle) ? 1'b0 : ovf_q;
    acc_d      = cla_Sum;
    hi_d       = hi_base + {{(HI_W-1){1'b0}}, cla_Cout};
    beats_d    = beats_base + BEAT_W'(1);
    ovf_d      = ovf_base | ((&hi_base) & cla_Cout);
`ifdef CLA_ACC_SAT_EN
    // Once overflowed, the sum pins at all-ones for the rest of the packet.
    if (ovf_d) begin
      acc_d = '1;
      hi_d  = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      hi_q    <= '0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (accept) begin
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            beats_q <= beats_d;
            ovf_q   <= ovf_d;
            state_q <= in_last ? StDone : StAccum;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_accumulator.sv
// Randomized bench for cla_accumulator: two instances (HI_W=16 and HI_W=2) share one stream,
// each paired with a behavioural adder, checked against a whole-packet arithmetic model.
module tb_cla_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

`ifdef CLA_ACC_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic        in_ready_a, out_valid_a, out_ovf_a, cout_a;
  logic [31:0] a_a, b_a, s_a;
  logic [47:0] sum_a;
  logic [7:0]  beats_a;

  logic        in_ready_b, out_valid_b, out_ovf_b, cout_b;
  logic [31:0] a_b, b_b, s_b;
  logic [33:0] sum_b;
  logic [7:0]  beats_b;

  int n_checks = 0;
  int n_fail = 0;

  assign {cout_a, s_a} = {1'b0, a_a} + {1'b0, b_a};
  assign {cout_b, s_b} = {1'b0, a_b} + {1'b0, b_b};

  cla_accumulator #(.HI_W(16), .BEAT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .in_last(in_last), .cla_A(a_a), .cla_B(b_a), .cla_Sum(s_a), .cla_Cout(cout_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(sum_a), .out_beats(beats_a),
    .out_ovf(out_ovf_a)
  );

  cla_accumulator #(.HI_W(2), .BEAT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_last(in_last), .cla_A(a_b), .cla_B(b_b), .cla_Sum(s_b), .cla_Cout(cout_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(sum_b), .out_beats(beats_b),
    .out_ovf(out_ovf_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_sum(input logic [63:0] total, input int hw);
    logic [63:0] mask;
    mask = (64'd1 << (32 + hw)) - 64'd1;
    if (Sat && total > mask) return mask;
    return total & mask;
  endfunction

  function automatic logic model_ovf(input logic [63:0] total, input int hw);
    return (total >> (32 + hw)) != 64'd0;
  endfunction

  task automatic check_reset_state();
    check("rst_valid_a", 64'(out_valid_a), 64'd0);
    check("rst_valid_b", 64'(out_valid_b), 64'd0);
    check("rst_sum_a", 64'(sum_a), 64'd0);
    check("rst_sum_b", 64'(sum_b), 64'd0);
    check("rst_beats_a", 64'(beats_a), 64'd0);
    check("rst_ovf_a", 64'(out_ovf_a), 64'd0);
    check("rst_ready_a", 64'(in_ready_a), 64'd1);
    check("rst_cla_a", 64'(a_a), 64'd0);
  endtask

  // Feeds words one per accept; optional random idle gaps carry junk that must be ignored.
  task automatic feed(input logic [31:0] words[$], input bit finish, input bit gaps);
    for (int i = 0; i < words.size(); i++) begin
      int g;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom);
        @(negedge clk);
      end
      check("no_early_valid_a", 64'(out_valid_a), 64'd0);
      check("in_ready_a", 64'(in_ready_a), 64'd1);
      in_valid = 1'b1;
      in_data  = words[i];
      in_last  = finish && (i == words.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called one cycle after the last accept; holds out_ready low for 'hold' cycles first.
  task automatic check_result(input logic [31:0] words[$], input int hold);
    logic [63:0] total;
    logic [63:0] ea, eb;
    total = '0;
    foreach (words[i]) total += 64'(words[i]);
    ea = model_sum(total, 16);
    eb = model_sum(total, 2);
    check("valid_a", 64'(out_valid_a), 64'd1);
    check("valid_b", 64'(out_valid_b), 64'd1);
    check("sum_a", 64'(sum_a), ea);
    check("sum_b", 64'(sum_b), eb);
    check("beats_a", 64'(beats_a), 64'(words.size() % 256));
    check("beats_b", 64'(beats_b), 64'(words.size() % 256));
    check("ovf_a", 64'(out_ovf_a), 64'(model_ovf(total, 16)));
    check("ovf_b", 64'(out_ovf_b), 64'(model_ovf(total, 2)));
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = 1'($urandom);
      check("bp_in_ready_a", 64'(in_ready_a), 64'd0);
      @(negedge clk);
      check("bp_valid_a", 64'(out_valid_a), 64'd1);
      check("bp_sum_a", 64'(sum_a), ea);
      check("bp_sum_b", 64'(sum_b), eb);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("consumed_valid_a", 64'(out_valid_a), 64'd0);
    check("consumed_valid_b", 64'(out_valid_b), 64'd0);
    check("consumed_ready_a", 64'(in_ready_a), 64'd1);
  endtask

  task automatic packet(input logic [31:0] words[$], input int hold, input bit gaps);
    feed(words, 1'b1, gaps);
    check_result(words, hold);
  endtask

  initial begin
    logic [31:0] q[$];
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    @(negedge clk);

    q = {32'd10, 32'd20};
    packet(q, 0, 1'b0);
    q = {32'd123, 32'd456, 32'd987654321, 32'd123456789};
    packet(q, 0, 1'b0);
    q = {32'hFFFF_FFFF, 32'h0000_0001};
    packet(q, 0, 1'b0);
    q = {32'd3, 32'd4};
    packet(q, 5, 1'b0);
    q = {32'd7};
    packet(q, 0, 1'b0);

    // Reset mid-packet discards the partial sum.
    q = {32'd100, 32'd200};
    feed(q, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    q = {32'd5};
    packet(q, 0, 1'b0);

    q = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    packet(q, 1, 1'b0);

    for (int p = 0; p < 40; p++) begin
      int len;
      len = int'($urandom_range(1, 8));
      q = {};
      for (int i = 0; i < len; i++)
        q.push_back($urandom_range(0, 1) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom);
      packet(q, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
